// File: rtl/irq_eoi_ctrl.sv
// -----------------------------------------------------------------------------
// irq_eoi_ctrl
// Interrupt front end between the IRQ input pads and the EOI output pads.
// Raw pad levels are synchronized and rising-edge detected into a pending
// register. A fixed-priority arbiter (lowest index wins) offers one interrupt
// at a time to the core over a valid/ack handshake. A matching
// end-of-interrupt command then drives a fixed-width one-hot pulse on the
// corresponding eoi line.
//
// Ports:
//   clk        block clock
//   rstn       asynchronous active-low reset
//   irq        raw pad levels, asynchronous to clk
//   irq_mask   1 = line excluded from arbitration (edges are still captured)
//   irq_valid  an interrupt is offered to the core
//   irq_id     index of the offered interrupt
//   irq_ack    core accepts the offered interrupt
//   eoi_req    single-cycle end-of-interrupt command
//   eoi_id     index being retired, sampled with eoi_req
//   eoi        one-hot pulse toward the EOI output pads
//   eoi_err    one-cycle flag for a rejected eoi_req
//   pending    pending register, for status/debug
// -----------------------------------------------------------------------------
module irq_eoi_ctrl #(
   parameter int  NUM_IRQ          = 16,
   parameter int  SYNC_STAGES      = 2,
   parameter int  EOI_PULSE_CYCLES = 4,
   localparam int ID_W             = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   output logic               irq_valid,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               eoi_req,
   input  logic [ID_W-1:0]    eoi_id,
   output logic [NUM_IRQ-1:0] eoi,
   output logic               eoi_err,
   output logic [NUM_IRQ-1:0] pending
);

   localparam int CNT_W = $clog2(EOI_PULSE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_OFFER     = 2'd1,
      ST_SERVICE   = 2'd2,
      ST_EOI_PULSE = 2'd3
   } state_e;

   // Shift-based decode stays in range for any NUM_IRQ, including non powers of two.
   function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
      logic [NUM_IRQ-1:0] one;
      one = {{(NUM_IRQ-1){1'b0}}, 1'b1};
      return one << id;
   endfunction

   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
   logic [NUM_IRQ-1:0]                  prev_q;
   logic [NUM_IRQ-1:0]                  edge_s;
   logic [NUM_IRQ-1:0]                  pending_q, pending_d;
   logic [NUM_IRQ-1:0]                  in_service_q, in_service_d;
   logic [NUM_IRQ-1:0]                  req_s;
   logic [ID_W-1:0]                     sel_id_s;
   logic                                ack_fire_s;
   logic                                eoi_hit_s;

   state_e                              state_q;
   logic                                irq_valid_q;
   logic [ID_W-1:0]                     irq_id_q;
   logic [NUM_IRQ-1:0]                  eoi_q;
   logic                                eoi_err_q;
   logic [CNT_W-1:0]                    cnt_q;

   // Synchronizer chain and edge history for every pad input.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= irq;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_s     = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign ack_fire_s = (state_q == ST_OFFER) && irq_ack;
   // in_service holds exactly the line being serviced, so a bit test is the id match.
   assign eoi_hit_s  = (state_q == ST_SERVICE) && eoi_req &&
                       ((in_service_q & id_onehot(eoi_id)) != '0);

   // Fixed-priority arbiter: descending scan so the lowest requesting index wins.
   always_comb begin
      req_s    = pending_q & ~irq_mask;
      sel_id_s = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req_s[i]) begin
            sel_id_s = ID_W'(i);
         end else begin
            sel_id_s = sel_id_s;
         end
      end
   end

   // Pending/in-service next state; a new edge overrides the ack clear.
   always_comb begin
      pending_d    = pending_q;
      in_service_d = in_service_q;
      if (ack_fire_s) begin
         pending_d    = pending_q & ~id_onehot(irq_id_q);
         in_service_d = in_service_q | id_onehot(irq_id_q);
      end else if (eoi_hit_s) begin
         in_service_d = in_service_q & ~id_onehot(eoi_id);
      end else begin
         in_service_d = in_service_q;
      end
      pending_d = pending_d | edge_s;
   end

   // Pending and in-service registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending_q    <= '0;
         in_service_q <= '0;
      end else begin
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end

   // Offer / service / EOI pulse sequencer with registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         irq_valid_q <= 1'b0;
         irq_id_q    <= '0;
         eoi_q       <= '0;
         eoi_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         eoi_err_q <= eoi_req && !eoi_hit_s;
         case (state_q)
            ST_IDLE: begin
               if (req_s != '0) begin
                  irq_id_q    <= sel_id_s;
                  irq_valid_q <= 1'b1;
                  state_q     <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               // No re-arbitration: id stays locked until the core acks.
               if (irq_ack) begin
                  irq_valid_q <= 1'b0;
                  state_q     <= ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (eoi_hit_s) begin
                  eoi_q   <= id_onehot(eoi_id);
                  cnt_q   <= CNT_W'(EOI_PULSE_CYCLES);
                  state_q <= ST_EOI_PULSE;
               end
            end
            ST_EOI_PULSE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  eoi_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               irq_valid_q <= 1'b0;
               eoi_q       <= '0;
               cnt_q       <= '0;
            end
         endcase
      end
   end

   assign irq_valid = irq_valid_q;
   assign irq_id    = irq_id_q;
   assign eoi       = eoi_q;
   assign eoi_err   = eoi_err_q;
   assign pending   = pending_q;

endmodule
